// File: rtl/branch_pkg.sv
// Shared encodings and the PC-to-BHT index helper for the branch unit.
package branch_pkg;

   // RV conditional-branch funct3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // 2-bit saturating counter states
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam int PC_MAX_W = 64;

   // Word-aligned PC bits select the entry: pc[idx_w+1:2]
   function automatic int unsigned bht_idx(input logic [PC_MAX_W-1:0] pc, input int idx_w);
      int unsigned mask;
      mask = (32'd1 << idx_w) - 32'd1;
      return 32'(pc >> 2) & mask;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational evaluation of the six RV branch conditions.
module branch_cmp
   import branch_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      funct3,
   output logic            cond,
   output logic            legal
);

   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic                   eq;
   logic                   lt_s;
   logic                   lt_u;

   assign rs1_s = rs1;
   assign rs2_s = rs2;
   assign eq    = (rs1 == rs2);
   assign lt_s  = (rs1_s < rs2_s);
   assign lt_u  = (rs1 < rs2);

   // Select the condition for funct3; reserved encodings are not branches
   always_comb begin
      cond  = 1'b0;
      legal = 1'b1;
      case (funct3)
         F3_BEQ:  cond = eq;
         F3_BNE:  cond = !eq;
         F3_BLT:  cond = lt_s;
         F3_BGE:  cond = !lt_s;
         F3_BLTU: cond = lt_u;
         F3_BGEU: cond = !lt_u;
         default: begin
            cond  = 1'b0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with a 2-bit saturating-counter BHT predictor.
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  fetch_pc,
   output logic             predict_taken,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   output logic             switch_branch,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   // Flop array so every entry can be reinitialised in one reset cycle
   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             cond;
   logic             legal;
   logic             resolve;
   logic             wrong;
   logic             mispred_p1;
   logic [XLEN-1:0]  redirect_p1;
   logic [CNT_W-1:0] branch_cnt_p1;
   logic [CNT_W-1:0] mispred_cnt_p1;

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
      if (taken)
         return (c == ST) ? ST : c + 2'b01;
      else
         return (c == SNT) ? SNT : c - 2'b01;
   endfunction

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .rs1    (rs1_data),
      .rs2    (rs2_data),
      .funct3 (funct3),
      .cond   (cond),
      .legal  (legal)
   );

   assign fetch_idx     = IDX_W'(bht_idx(PC_MAX_W'(fetch_pc), IDX_W));
   assign ex_idx        = IDX_W'(bht_idx(PC_MAX_W'(ex_pc), IDX_W));
   // An instruction in EX while a redirect is signalled is wrong-path
   assign resolve       = ex_valid & ex_branch & legal & !mispred_p1;
   assign switch_branch = resolve & cond;
   assign wrong         = switch_branch != ex_pred_taken;
   // Combinational read sees the pre-update entry on a same-index write
   assign predict_taken = bht[fetch_idx][1];

   // ---- stage p1: registered resolution, BHT training and counters ----
   always_ff @(posedge clk) begin
      if (reset) begin
         mispred_p1     <= 1'b0;
         redirect_p1    <= '0;
         branch_cnt_p1  <= '0;
         mispred_cnt_p1 <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= WNT;
      end else begin
         mispred_p1 <= resolve & wrong;
         if (resolve) begin
            redirect_p1   <= switch_branch ? ex_target : ex_pc + XLEN'(4);
            bht[ex_idx]   <= bht_next(bht[ex_idx], switch_branch);
            branch_cnt_p1 <= cnt_sat_inc(branch_cnt_p1);
            if (wrong)
               mispred_cnt_p1 <= cnt_sat_inc(mispred_cnt_p1);
         end
      end
   end

   assign mispredict    = mispred_p1;
   assign redirect_pc   = redirect_p1;
   assign branch_count  = branch_cnt_p1;
   assign mispred_count = mispred_cnt_p1;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit with a scoreboard of expected results.
module tb_branch_predict_unit;
   import branch_pkg::*;

   localparam int XLEN        = 64;
   localparam int BHT_ENTRIES = 16;
   localparam int CNT_W       = 4;

   typedef struct {
      logic             sw;
      logic             mp;
      logic [XLEN-1:0]  rpc;
      logic [CNT_W-1:0] bc;
      logic [CNT_W-1:0] mc;
   } exp_t;

   typedef struct {
      logic            v;
      logic [2:0]      f3;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tgt;
      logic            pred;
   } stim_t;

   logic             clk;
   logic             reset;
   logic [XLEN-1:0]  fetch_pc;
   logic             predict_taken;
   logic             ex_valid;
   logic             ex_branch;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_target;
   logic             ex_pred_taken;
   logic             switch_branch;
   logic             mispredict;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispred_count;

   exp_t             sb [$];
   int               n_chk = 0;
   int               n_err = 0;

   logic [1:0]       m_bht [BHT_ENTRIES];
   logic             m_mp;
   logic [XLEN-1:0]  m_rpc;
   logic [CNT_W-1:0] m_bc;
   logic [CNT_W-1:0] m_mc;

   branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_pc      (fetch_pc),
      .predict_taken (predict_taken),
      .ex_valid      (ex_valid),
      .ex_branch     (ex_branch),
      .funct3        (funct3),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .ex_pc         (ex_pc),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .switch_branch (switch_branch),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .branch_count  (branch_count),
      .mispred_count (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 2'b01;
      m_mp  = 1'b0;
      m_rpc = '0;
      m_bc  = '0;
      m_mc  = '0;
      sb.delete();
   endtask

   // Drive one EX cycle, advance the reference model across the next edge, queue the expectation
   task automatic drive(input stim_t s);
      logic legal, cnd, res, sw;
      int   idx;
      exp_t e;
      ex_valid      = s.v;
      ex_branch     = s.v;
      funct3        = s.f3;
      rs1_data      = s.a;
      rs2_data      = s.b;
      ex_pc         = s.pc;
      ex_target     = s.tgt;
      ex_pred_taken = s.pred;
      legal = 1'b1;
      cnd   = 1'b0;
      case (s.f3)
         3'b000:  cnd = (s.a == s.b);
         3'b001:  cnd = (s.a != s.b);
         3'b100:  cnd = ($signed(s.a) <  $signed(s.b));
         3'b101:  cnd = ($signed(s.a) >= $signed(s.b));
         3'b110:  cnd = (s.a <  s.b);
         3'b111:  cnd = (s.a >= s.b);
         default: legal = 1'b0;
      endcase
      res = s.v & legal & !m_mp;
      sw  = res & cnd;
      if (res) begin
         m_rpc = sw ? s.tgt : s.pc + 64'd4;
         idx   = int'(s.pc[5:2]);
         if (sw && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
         else if (!sw && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
         if (m_bc != '1) m_bc = m_bc + 1'b1;
         if (sw != s.pred && m_mc != '1) m_mc = m_mc + 1'b1;
      end
      m_mp = res & (sw != s.pred);
      e = '{sw, m_mp, m_rpc, m_bc, m_mc};
      sb.push_back(e);
   endtask

   function automatic stim_t mk(input logic v, input logic [2:0] f3, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                input logic [XLEN-1:0] tgt, input logic pred);
      stim_t s;
      s = '{v, f3, a, b, pc, tgt, pred};
      return s;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      ex_valid = 1'b0; ex_branch = 1'b0; funct3 = 3'b000;
      rs1_data = '0; rs2_data = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
      fetch_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      n_chk++;
      if ({mispredict, redirect_pc, branch_count, mispred_count} !== {1'b0, 64'd0, 4'd0, 4'd0}) begin
         n_err++;
         $display("FAIL reset_state: got mp=%0b rpc=%h bc=%0d mc=%0d want all zero",
                  mispredict, redirect_pc, branch_count, mispred_count);
      end
      for (int i = 0; i < BHT_ENTRIES; i++) begin
         fetch_pc = 64'(i) << 2;
         #1;
         n_chk++;
         if (predict_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_predict idx=%0d: got %0b want 0", i, predict_taken);
         end
      end
   endtask

   task automatic test_beq();
      stim_t st [2];
      exp_t  e;
      st[0] = mk(1'b1, F3_BEQ, 64'd5, 64'd5, 64'h40, 64'h100, 1'b0);
      st[1] = mk(1'b0, F3_BEQ, 64'd0, 64'd0, 64'h0, 64'h0, 1'b0);
      fetch_pc = 64'h40;
      for (int k = 0; k < 2; k++) begin
         drive(st[k]);
         #1; n_chk++;
         if (switch_branch !== sb[0].sw) begin
            n_err++; $display("FAIL beq_switch step=%0d: got %0b want %0b", k, switch_branch, sb[0].sw);
         end
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !==
             {e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]}) begin
            n_err++;
            $display("FAIL beq_result step=%0d: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b",
                     k, mispredict, redirect_pc, branch_count, mispred_count, predict_taken,
                     e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]);
         end
         if (k == 0) begin
            n_chk++;
            if ({mispredict, redirect_pc, mispred_count, predict_taken} !== {1'b1, 64'h100, 4'd1, 1'b1}) begin
               n_err++;
               $display("FAIL beq_fixed: got mp=%0b rpc=%h mc=%0d pt=%0b want 1 100 1 1",
                        mispredict, redirect_pc, mispred_count, predict_taken);
            end
         end
      end
   endtask

   task automatic test_compare();
      logic [2:0] f3s  [7];
      logic       want [7];
      exp_t       e;
      f3s  = '{F3_BLT, F3_BLTU, F3_BGE, F3_BGEU, 3'b010, 3'b011, F3_BNE};
      want = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 7; k++) begin
         fetch_pc = 64'h100 + 64'(k) * 4;
         drive(mk(1'b1, f3s[k], '1, 64'd1, fetch_pc, 64'h800, want[k]));
         #1; n_chk++;
         if (switch_branch !== want[k] || sb[0].sw !== want[k]) begin
            n_err++; $display("FAIL cmp_switch f3=%b: got %0b want %0b", f3s[k], switch_branch, want[k]);
         end
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !==
             {e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]}) begin
            n_err++;
            $display("FAIL cmp_result f3=%b: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b",
                     f3s[k], mispredict, redirect_pc, branch_count, mispred_count, predict_taken,
                     e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]);
         end
      end
   endtask

   task automatic test_saturate();
      stim_t st [10];
      exp_t  e;
      for (int k = 0; k < 4; k++) begin
         st[2*k]   = mk(1'b1, F3_BEQ, 64'd9, 64'd9, 64'h3C, 64'h600, 1'b0);
         st[2*k+1] = mk(1'b0, F3_BEQ, 64'd0, 64'd0, 64'h0, 64'h0, 1'b0);
      end
      st[8] = mk(1'b1, F3_BNE, 64'd9, 64'd9, 64'h3C, 64'h600, 1'b1);
      st[9] = mk(1'b0, F3_BEQ, 64'd0, 64'd0, 64'h0, 64'h0, 1'b0);
      fetch_pc = 64'h3C;
      for (int k = 0; k < 10; k++) begin
         if (k < 8 && k % 2 == 0) st[k].pred = m_bht[15][1];
         drive(st[k]);
         #1; n_chk++;
         if (switch_branch !== sb[0].sw) begin
            n_err++; $display("FAIL sat_switch step=%0d: got %0b want %0b", k, switch_branch, sb[0].sw);
         end
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !==
             {e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]}) begin
            n_err++;
            $display("FAIL sat_result step=%0d: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b",
                     k, mispredict, redirect_pc, branch_count, mispred_count, predict_taken,
                     e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]);
         end
         if (k == 8) begin
            n_chk++;
            if ({mispredict, redirect_pc, predict_taken} !== {1'b1, 64'h40, 1'b1}) begin
               n_err++;
               $display("FAIL sat_untaken: got mp=%0b rpc=%h pt=%0b want 1 40 1", mispredict, redirect_pc, predict_taken);
            end
         end
      end
   endtask

   task automatic test_squash();
      stim_t st [3];
      exp_t  e;
      st[0] = mk(1'b1, F3_BEQ, 64'd7, 64'd7, 64'h44, 64'h500, 1'b0);
      st[1] = mk(1'b1, F3_BNE, 64'd7, 64'd7, 64'h44, 64'h500, 1'b1);
      st[2] = mk(1'b1, F3_BEQ, 64'd7, 64'd7, 64'h44, 64'h500, 1'b0);
      fetch_pc = 64'h44;
      for (int k = 0; k < 3; k++) begin
         drive(st[k]);
         #1; n_chk++;
         if (switch_branch !== sb[0].sw) begin
            n_err++; $display("FAIL squash_switch step=%0d: got %0b want %0b", k, switch_branch, sb[0].sw);
         end
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !==
             {e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]}) begin
            n_err++;
            $display("FAIL squash_result step=%0d: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b",
                     k, mispredict, redirect_pc, branch_count, mispred_count, predict_taken,
                     e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]);
         end
      end
      // mispredict is pending now; reset with another mispredicting branch in EX
      reset = 1'b1;
      ex_valid = 1'b1; ex_branch = 1'b1; funct3 = F3_BEQ;
      rs1_data = 64'd1; rs2_data = 64'd1; ex_pc = 64'h44; ex_target = 64'h900; ex_pred_taken = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      ex_valid = 1'b0; ex_branch = 1'b0;
      model_reset();
      n_chk++;
      if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !== {1'b0, 64'd0, 4'd0, 4'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_midrun: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want all zero",
                  mispredict, redirect_pc, branch_count, mispred_count, predict_taken);
      end
   endtask

   task automatic test_same_index();
      logic old_pt;
      exp_t e;
      fetch_pc = 64'h48;
      old_pt = m_bht[2][1];
      drive(mk(1'b1, F3_BEQ, 64'd3, 64'd3, 64'h48, 64'h700, 1'b0));
      #1; n_chk++;
      if (predict_taken !== old_pt || switch_branch !== 1'b1) begin
         n_err++;
         $display("FAIL same_idx_before: got pt=%0b sw=%0b want pt=%0b sw=1", predict_taken, switch_branch, old_pt);
      end
      @(posedge clk); #1;
      e = sb.pop_front(); n_chk++;
      if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !==
          {e.mp, e.rpc, e.bc, e.mc, 1'b1}) begin
         n_err++;
         $display("FAIL same_idx_after: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want mp=%0b rpc=%h bc=%0d mc=%0d pt=1",
                  mispredict, redirect_pc, branch_count, mispred_count, predict_taken, e.mp, e.rpc, e.bc, e.mc);
      end
   endtask

   task automatic test_counter_sat();
      exp_t e;
      fetch_pc = 64'h4C;
      for (int k = 0; k < 40; k++) begin
         if (k % 2 == 0) drive(mk(1'b1, F3_BGEU, 64'd8, 64'd2, 64'h4C, 64'hA00, 1'b0));
         else            drive(mk(1'b0, F3_BEQ, 64'd0, 64'd0, 64'h0, 64'h0, 1'b0));
         #1; n_chk++;
         if (switch_branch !== sb[0].sw) begin
            n_err++; $display("FAIL cnt_switch step=%0d: got %0b want %0b", k, switch_branch, sb[0].sw);
         end
         @(posedge clk); #1;
         e = sb.pop_front(); n_chk++;
         if ({mispredict, redirect_pc, branch_count, mispred_count, predict_taken} !==
             {e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]}) begin
            n_err++;
            $display("FAIL cnt_result step=%0d: got mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b want mp=%0b rpc=%h bc=%0d mc=%0d pt=%0b",
                     k, mispredict, redirect_pc, branch_count, mispred_count, predict_taken,
                     e.mp, e.rpc, e.bc, e.mc, m_bht[fetch_pc[5:2]][1]);
         end
      end
      n_chk++;
      if (branch_count !== 4'hF || mispred_count !== 4'hF) begin
         n_err++;
         $display("FAIL cnt_saturate: got bc=%0d mc=%0d want 15 15", branch_count, mispred_count);
      end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_compare();
      test_saturate();
      test_squash();
      test_same_index();
      test_counter_sat();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
